// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between fetch and data stages with timeout abort
module mem_port_arbiter #(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic [63:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_dm
);
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;
  localparam int WW = FAIR_LIMIT > 0 ? $clog2(FAIR_LIMIT + 1) : 1;
  state_t        state;
  logic [WW-1:0] win_cnt;
  logic [9:0]    tmo_cnt;
  logic          grant_if, grant_dm, tmo_hit, fair_hit;
  logic [31:0]   lane;
  assign fair_hit = win_cnt == WW'(FAIR_LIMIT);
  assign grant_if = if_req & (~dm_req | fair_hit);
  assign grant_dm = dm_req & ~grant_if;
  assign tmo_hit  = tmo_cnt == 10'(TIMEOUT - 1);
  // mem_addr holds the latched fetch address, so its bit 2 picks the lane
  assign lane     = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_inst   <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      dm_err    <= 1'b0;
      win_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if | grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_dm & dm_we;
            mem_addr  <= grant_if ? {32'b0, if_addr} : dm_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            tmo_cnt   <= '0;
            win_cnt   <= (grant_dm & if_req) ? win_cnt + WW'(!fair_hit) : '0;
            state     <= grant_if ? IF_ACC : DM_ACC;
          end
        end
        IF_ACC, DM_ACC: begin
          tmo_cnt <= tmo_cnt + 10'd1;
          if (mem_ack | tmo_hit) begin
            mem_req <= 1'b0;
            dm_err  <= ~mem_ack;
            state   <= RESP;
            if (state == IF_ACC) begin
              if_inst  <= mem_ack ? lane : '0;
              if_valid <= 1'b1;
            end else begin
              dm_rdata <= (mem_ack & ~mem_we) ? mem_rdata : '0;
              dm_valid <= 1'b1;
            end
          end
        end
        default: begin
          dm_err <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule
